// File: rtl/pong_pkg.sv
// Shared constants for the pong game sequencer: state codes and winner codes.
package pong_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] MENU      = 3'd0;
  localparam logic [STATE_W-1:0] SET       = 3'd1;
  localparam logic [STATE_W-1:0] START     = 3'd2;
  localparam logic [STATE_W-1:0] PLAY      = 3'd3;
  localparam logic [STATE_W-1:0] END_POINT = 3'd4;
  localparam logic [STATE_W-1:0] END_GAME  = 3'd5;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P1   = 2'd1;
  localparam logic [1:0] WINNER_P2   = 2'd2;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bundle of button/hit/frame inputs and game status outputs around pong_game_ctrl.
// master = the game controller, slave = the datapath/button side.
interface pong_game_ctrl_if
  import pong_pkg::*;
#(
  parameter int SCORE_W = 5
);
  logic               frame_tick;
  logic               btn_launch;
  logic               btn_up;
  logic               btn_down;
  logic               left_hit;
  logic               right_hit;
  logic [STATE_W-1:0] state;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [SCORE_W-1:0] max_score;
  logic               serve_side;
  logic               ball_load;
  logic               play_en;
  logic [1:0]         winner;

  modport master (
    input  frame_tick, btn_launch, btn_up, btn_down, left_hit, right_hit,
    output state, score_p1, score_p2, max_score, serve_side, ball_load, play_en, winner
  );

  modport slave (
    output frame_tick, btn_launch, btn_up, btn_down, left_hit, right_hit,
    input  state, score_p1, score_p2, max_score, serve_side, ball_load, play_en, winner
  );
endinterface

// File: rtl/pong_btn_edge.sv
// Rising-edge detector for a synchronised button level: one-clk pulse per press.
module pong_btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic rise
);
  logic btn_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) btn_q <= 1'b0;
    else          btn_q <= btn;
  end

  assign rise = btn & ~btn_q;
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: FSM, scores, target score, serve side and datapath gating.
// Define AUTO_SERVE_EN to leave START automatically after SERVE_FRAMES frame ticks.
//
// state     | meaning
// MENU      | idle, waiting for launch
// SET       | up/down adjust max_score, launch starts the match
// START     | ball and paddles re-centred (ball_load), waiting to serve
// PLAY      | ball animated (play_en), waiting for a wall hit
// END_POINT | pause after a point, END_POINT_FRAMES frame ticks
// END_GAME  | winner shown, launch returns to MENU
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_W          = 5,
  parameter int MAX_SCORE_DEF    = 5,
  parameter int MAX_SCORE_MIN    = 1,
  parameter int MAX_SCORE_MAX    = 21,
  parameter int END_POINT_FRAMES = 60,
  parameter int SERVE_FRAMES     = 120
) (
  input  logic             clk,
  input  logic             reset_n,
  pong_game_ctrl_if.master bus
);
  // One width covers both frame timers.
  localparam int CNT_MAX = (END_POINT_FRAMES > SERVE_FRAMES) ? END_POINT_FRAMES : SERVE_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic               launch_rise, up_rise, down_rise;
  logic [STATE_W-1:0] state_q, state_d;
  logic [SCORE_W-1:0] score_p1_q, score_p2_q, max_score_q;
  logic [SCORE_W-1:0] p1_inc, p2_inc;
  logic               serve_side_q;
  logic [1:0]         winner_q;
  logic               ball_load_q, ball_load_d;
  logic               play_en_q, play_en_d;
  logic [CNT_W-1:0]   end_cnt;
  logic               p1_point, p2_point, end_done;

  pong_btn_edge u_launch (.clk(clk), .reset_n(reset_n), .btn(bus.btn_launch), .rise(launch_rise));
  pong_btn_edge u_up     (.clk(clk), .reset_n(reset_n), .btn(bus.btn_up),     .rise(up_rise));
  pong_btn_edge u_down   (.clk(clk), .reset_n(reset_n), .btn(bus.btn_down),   .rise(down_rise));

  assign p1_point = (state_q == PLAY) && bus.right_hit && !bus.left_hit;
  assign p2_point = (state_q == PLAY) && bus.left_hit && !bus.right_hit;
  assign p1_inc   = score_p1_q + 1'b1;
  assign p2_inc   = score_p2_q + 1'b1;
  assign end_done = bus.frame_tick && (end_cnt == '0);

`ifdef AUTO_SERVE_EN
  logic [CNT_W-1:0] serve_cnt;
  logic             serve_done;

  assign serve_done = bus.frame_tick && (serve_cnt == '0);

  // Loaded on entry to START so the terminal count lands on the SERVE_FRAMES-th tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                serve_cnt <= '0;
    else if (state_d == START && state_q != START) serve_cnt <= CNT_W'(SERVE_FRAMES - 1);
    else if (state_q == START) begin
      if (state_d != START)     serve_cnt <= '0;
      else if (bus.frame_tick)  serve_cnt <= serve_cnt - 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= MENU;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MENU:      if (launch_rise) state_d = SET;
      SET:       if (launch_rise) state_d = START;
`ifdef AUTO_SERVE_EN
      START:     if (launch_rise || serve_done) state_d = PLAY;
`else
      START:     if (launch_rise) state_d = PLAY;
`endif
      PLAY:      if (bus.left_hit || bus.right_hit) state_d = END_POINT;
      END_POINT: if (end_done) state_d = (winner_q != WINNER_NONE) ? END_GAME : START;
      END_GAME:  if (launch_rise) state_d = MENU;
      default:   state_d = MENU;
    endcase
  end

  always_comb begin
    ball_load_d = (state_d == START);
    play_en_d   = (state_d == PLAY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ball_load_q <= 1'b0;
      play_en_q   <= 1'b0;
    end else begin
      ball_load_q <= ball_load_d;
      play_en_q   <= play_en_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  end_cnt <= '0;
    else if (state_q == PLAY && state_d == END_POINT) end_cnt <= CNT_W'(END_POINT_FRAMES - 1);
    else if (state_q == END_POINT) begin
      if (state_d != END_POINT) end_cnt <= '0;
      else if (bus.frame_tick)  end_cnt <= end_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_score_q  <= SCORE_W'(MAX_SCORE_DEF);
      score_p1_q   <= '0;
      score_p2_q   <= '0;
      serve_side_q <= 1'b0;
      winner_q     <= WINNER_NONE;
    end else begin
      if (state_q == SET) begin
        if (up_rise && !down_rise && max_score_q < SCORE_W'(MAX_SCORE_MAX))
          max_score_q <= max_score_q + 1'b1;
        else if (down_rise && !up_rise && max_score_q > SCORE_W'(MAX_SCORE_MIN))
          max_score_q <= max_score_q - 1'b1;
        if (launch_rise) begin
          score_p1_q <= '0;
          score_p2_q <= '0;
          winner_q   <= WINNER_NONE;
        end
      end
      // Increment is guarded so a score can never pass max_score.
      if (p1_point) begin
        serve_side_q <= 1'b1;
        if (score_p1_q < max_score_q) score_p1_q <= p1_inc;
        if (p1_inc == max_score_q)    winner_q   <= WINNER_P1;
      end
      if (p2_point) begin
        serve_side_q <= 1'b0;
        if (score_p2_q < max_score_q) score_p2_q <= p2_inc;
        if (p2_inc == max_score_q)    winner_q   <= WINNER_P2;
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.score_p1   = score_p1_q;
  assign bus.score_p2   = score_p2_q;
  assign bus.max_score  = max_score_q;
  assign bus.serve_side = serve_side_q;
  assign bus.ball_load  = ball_load_q;
  assign bus.play_en    = play_en_q;
  assign bus.winner     = winner_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl.
module tb_pong_game_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  pong_game_ctrl_if #(.SCORE_W(5)) bus ();

  pong_game_ctrl u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_launch();
    bus.btn_launch = 1'b1; step();
    bus.btn_launch = 1'b0; step();
  endtask

  task automatic press_updown(input logic up, input logic down);
    bus.btn_up = up; bus.btn_down = down; step();
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; step();
  endtask

  task automatic pulse_hit(input logic l, input logic r);
    bus.left_hit = l; bus.right_hit = r; step();
    bus.left_hit = 1'b0; bus.right_hit = 1'b0; step();
  endtask

  task automatic frame_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1; step();
      bus.frame_tick = 1'b0; step();
    end
  endtask

  // Compare {state, score_p1, score_p2, max_score, serve_side, ball_load, play_en, winner}.
  task automatic expect_all(input string name, input logic [2:0] st, input logic [4:0] p1,
                            input logic [4:0] p2, input logic [4:0] mx, input logic srv,
                            input logic bl, input logic pe, input logic [1:0] win);
    checks++;
    if ({bus.state, bus.score_p1, bus.score_p2, bus.max_score, bus.serve_side,
         bus.ball_load, bus.play_en, bus.winner} !== {st, p1, p2, mx, srv, bl, pe, win}) begin
      errors++;
      $display("FAIL %s: got st=%0d p1=%0d p2=%0d max=%0d srv=%0d bl=%0d pe=%0d win=%0d, want st=%0d p1=%0d p2=%0d max=%0d srv=%0d bl=%0d pe=%0d win=%0d",
               name, bus.state, bus.score_p1, bus.score_p2, bus.max_score, bus.serve_side,
               bus.ball_load, bus.play_en, bus.winner, st, p1, p2, mx, srv, bl, pe, win);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    expect_all("reset", 3'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0);
    press_launch();
    expect_all("menu_to_set", 3'd1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0);
    press_launch();
    expect_all("set_to_start", 3'd2, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_max_score();
    do_reset();
    press_launch();
    for (int i = 0; i < 20; i++) press_updown(1'b1, 1'b0);
    expect_all("max_sat_high", 3'd1, 5'd0, 5'd0, 5'd21, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 25; i++) press_updown(1'b0, 1'b1);
    expect_all("max_sat_low", 3'd1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0);
    press_updown(1'b1, 1'b1);
    expect_all("max_both_at_min", 3'd1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 2'd0);
    press_updown(1'b1, 1'b0);
    press_updown(1'b1, 1'b0);
    expect_all("max_up_to_3", 3'd1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0);
    press_updown(1'b1, 1'b1);
    expect_all("max_both_mid", 3'd1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0);
    // A held button is one press only.
    bus.btn_up = 1'b1; repeat (4) step(); bus.btn_up = 1'b0; step();
    press_updown(1'b0, 1'b1);
    expect_all("max_held_btn", 3'd1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0);
    press_launch();
    expect_all("start_max3", 3'd2, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_point();
    pulse_hit(1'b0, 1'b1);
    expect_all("hit_in_start_ignored", 3'd2, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 2'd0);
    press_launch();
    expect_all("play", 3'd3, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 2'd0);
    pulse_hit(1'b0, 1'b1);
    expect_all("p1_point", 3'd4, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0);
    press_launch();
    expect_all("launch_in_end_point", 3'd4, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0);
    frame_ticks(59);
    expect_all("end_point_59", 3'd4, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0);
    frame_ticks(1);
    expect_all("end_point_60", 3'd2, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_both_hits();
    press_launch();
    press_launch();
    expect_all("launch_in_play", 3'd3, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 2'd0);
    pulse_hit(1'b1, 1'b1);
    expect_all("both_hits", 3'd4, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0);
    frame_ticks(60);
    expect_all("both_hits_back", 3'd2, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_win();
    for (int i = 1; i <= 2; i++) begin
      press_launch();
      pulse_hit(1'b1, 1'b0);
      expect_all("p2_point", 3'd4, 5'd1, 5'(i), 5'd3, 1'b0, 1'b0, 1'b0, 2'd0);
      frame_ticks(60);
    end
    press_launch();
    pulse_hit(1'b1, 1'b0);
    expect_all("p2_wins", 3'd4, 5'd1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 2'd2);
    frame_ticks(60);
    expect_all("end_game", 3'd5, 5'd1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 2'd2);
    pulse_hit(1'b0, 1'b1);
    expect_all("hit_in_end_game", 3'd5, 5'd1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 2'd2);
    press_launch();
    expect_all("back_to_menu", 3'd0, 5'd1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 2'd2);
    press_launch();
    press_launch();
    expect_all("scores_cleared", 3'd2, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic test_async_reset();
    press_launch();
    pulse_hit(1'b0, 1'b1);
    frame_ticks(10);
    expect_all("pre_reset", 3'd4, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0);
    #2 reset_n = 1'b0;
    #1;
    expect_all("async_reset", 3'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    expect_all("after_release", 3'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_auto_serve();
    press_launch();
    press_launch();
    frame_ticks(119);
    expect_all("serve_119", 3'd2, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 2'd0);
    frame_ticks(1);
`ifdef AUTO_SERVE_EN
    expect_all("auto_serve_120", 3'd3, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 2'd0);
`else
    expect_all("no_auto_serve", 3'd2, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 2'd0);
`endif
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.btn_launch = 1'b0;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.left_hit   = 1'b0;
    bus.right_hit  = 1'b0;
    test_reset();
    test_max_score();
    test_point();
    test_both_hits();
    test_win();
    test_async_reset();
    test_auto_serve();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
